// File: rtl/rtc_bus_arbiter.sv
// Fixed-priority arbiter for the 8-bit multiplexed RTC bus (init > write > read).
// Runs one address phase and one data phase per grant, with all bus outputs registered.
module rtc_bus_arbiter #(
    parameter int unsigned T_PH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [2:0]  req_i,
    input  logic [2:0]  req_we_i,
    input  logic [23:0] req_addr_i,
    input  logic [23:0] req_wdata_i,
    output logic [2:0]  grant_o,
    output logic [2:0]  done_o,
    output logic        busy_o,
    output logic [7:0]  rdata_o,
    input  logic [7:0]  bus_in_i,
    output logic [7:0]  bus_out_o,
    output logic        bus_oe_o,
    output logic        cs_n_o,
    output logic        ad_o,
    output logic        wr_n_o,
    output logic        rd_n_o
);

    typedef enum logic [2:0] {
        StIdle,
        StASu,
        StASt,
        StAHd,
        StDSu,
        StDSt,
        StDHd,
        StDone
    } state_e;

    localparam logic [7:0] CntLoad = 8'(T_PH - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [2:0]  grant_q, grant_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [2:0]  done_q, done_d;
    logic [7:0]  bus_out_q, bus_out_d;
    logic        bus_oe_q, bus_oe_d;
    logic        cs_n_q, cs_n_d;
    logic        ad_q, ad_d;
    logic        wr_n_q, wr_n_d;
    logic        rd_n_q, rd_n_d;

    logic        addr_phase, data_phase;

    // Next state, phase timing and capture of the winning request.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        grant_d = grant_q;
        rdata_d = rdata_q;

        unique case (state_q)
            StIdle: begin
                if (req_i[0]) begin
                    state_d = StASu;
                    grant_d = 3'b001;
                    we_d    = req_we_i[0];
                    addr_d  = req_addr_i[7:0];
                    wdata_d = req_wdata_i[7:0];
                end else if (req_i[1]) begin
                    state_d = StASu;
                    grant_d = 3'b010;
                    we_d    = req_we_i[1];
                    addr_d  = req_addr_i[15:8];
                    wdata_d = req_wdata_i[15:8];
                end else if (req_i[2]) begin
                    state_d = StASu;
                    grant_d = 3'b100;
                    we_d    = req_we_i[2];
                    addr_d  = req_addr_i[23:16];
                    wdata_d = req_wdata_i[23:16];
                end
            end
            StASu:  if (cnt_q == 8'd0) state_d = StASt;
            StASt:  if (cnt_q == 8'd0) state_d = StAHd;
            StAHd:  if (cnt_q == 8'd0) state_d = StDSu;
            StDSu:  if (cnt_q == 8'd0) state_d = StDSt;
            StDSt: begin
                if (cnt_q == 8'd0) begin
                    state_d = StDHd;
                    if (!we_q) rdata_d = bus_in_i;
                end
            end
            StDHd:  if (cnt_q == 8'd0) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (state_d == StIdle) grant_d = 3'b000;

        // Counter reloads on any state change so each timed phase lasts T_PH cycles.
        if (state_d != state_q) begin
            cnt_d = CntLoad;
        end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    // Bus outputs are derived from the next state so they register in step with it.
    always_comb begin
        addr_phase = (state_d == StASu) || (state_d == StASt) || (state_d == StAHd);
        data_phase = (state_d == StDSu) || (state_d == StDSt) || (state_d == StDHd);

        done_d    = 3'b000;
        bus_out_d = 8'h00;
        bus_oe_d  = 1'b0;
        cs_n_d    = 1'b1;
        ad_d      = 1'b1;
        wr_n_d    = 1'b1;
        rd_n_d    = 1'b1;

        if (addr_phase) begin
            cs_n_d    = 1'b0;
            ad_d      = 1'b0;
            bus_oe_d  = 1'b1;
            bus_out_d = addr_d;
            wr_n_d    = (state_d != StASt);
        end else if (data_phase) begin
            cs_n_d = 1'b0;
            if (we_d) begin
                bus_oe_d  = 1'b1;
                bus_out_d = wdata_d;
                wr_n_d    = (state_d != StDSt);
            end else begin
                rd_n_d = (state_d != StDSt);
            end
        end else if (state_d == StDone) begin
            done_d = grant_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            cnt_q     <= 8'd0;
            we_q      <= 1'b0;
            addr_q    <= 8'h00;
            wdata_q   <= 8'h00;
            grant_q   <= 3'b000;
            rdata_q   <= 8'h00;
            done_q    <= 3'b000;
            bus_out_q <= 8'h00;
            bus_oe_q  <= 1'b0;
            cs_n_q    <= 1'b1;
            ad_q      <= 1'b1;
            wr_n_q    <= 1'b1;
            rd_n_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            grant_q   <= grant_d;
            rdata_q   <= rdata_d;
            done_q    <= done_d;
            bus_out_q <= bus_out_d;
            bus_oe_q  <= bus_oe_d;
            cs_n_q    <= cs_n_d;
            ad_q      <= ad_d;
            wr_n_q    <= wr_n_d;
            rd_n_q    <= rd_n_d;
        end
    end

    assign grant_o   = grant_q;
    assign done_o    = done_q;
    assign busy_o    = (state_q != StIdle);
    assign rdata_o   = rdata_q;
    assign bus_out_o = bus_out_q;
    assign bus_oe_o  = bus_oe_q;
    assign cs_n_o    = cs_n_q;
    assign ad_o      = ad_q;
    assign wr_n_o    = wr_n_q;
    assign rd_n_o    = rd_n_q;

endmodule
